// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types for the DMA timing & control sequencer.
//   state_t  : bus-cycle states SI (idle), S0 (hold request), S1..S4, SW (wait)
//   mode_t   : per-channel transfer mode (single / block / demand)
//   xfer_t   : per-channel transfer type (verify / write / read)
// Helper functions decode the raw 2-bit programming fields; the reserved
// encodings fall back to single mode and verify transfers respectively.
// -----------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_BLOCK  = 2'd1,
        MODE_DEMAND = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        XFER_VERIFY = 2'd0,
        XFER_WRITE  = 2'd1,
        XFER_READ   = 2'd2
    } xfer_t;

    function automatic mode_t decode_mode(input logic [1:0] field);
        case (field)
            2'b01:   return MODE_BLOCK;
            2'b10:   return MODE_DEMAND;
            default: return MODE_SINGLE;
        endcase
    endfunction

    function automatic xfer_t decode_xfer(input logic [1:0] field);
        case (field)
            2'b01:   return XFER_WRITE;
            2'b10:   return XFER_READ;
            default: return XFER_VERIFY;
        endcase
    endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// -----------------------------------------------------------------------------
// dma_priority_arbiter
// Combinational rotating-priority arbiter. The channel at index 'pointer' has
// the highest priority, then pointer+1, ... wrapping modulo NUM_CH. A pointer
// held at 0 gives plain fixed priority (channel 0 highest).
// Ports:
//   pending     in  NUM_CH  requesting channels (already masked)
//   pointer     in  CH_W    index of the highest-priority channel
//   grant       out CH_W    winning channel index (0 when nothing pending)
//   grant_valid out 1       at least one channel pending
// -----------------------------------------------------------------------------
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   pointer,
    output logic [CH_W-1:0]   grant,
    output logic              grant_valid
);

    // Candidate channel for each priority offset, and whether it requests.
    logic [CH_W-1:0]   cand [NUM_CH];
    logic [NUM_CH-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_offset
            assign cand[gi] = CH_W'((32'(pointer) + gi) % NUM_CH);
            assign hit[gi]  = pending[cand[gi]];
        end
    endgenerate

    // Scan from the lowest-priority offset upwards so the highest-priority
    // hit is the last one written.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant       = cand[i];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_multichannel_timing_ctrl.sv
// -----------------------------------------------------------------------------
// dma_multichannel_timing_ctrl
// N-channel DMA timing & control sequencer. Arbitrates channel requests, runs
// the HRQ/HLDA hold handshake and the SI/S0/S1/S2/S3/SW/S4 bus cycle, and
// drives the acknowledge, address-enable/strobe, read/write strobes and the
// count-update pulse to the address/count block.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   cs_n              CPU programming cycle (low) -- blocks new requests in SI
//   dreq, ch_mask     per-channel request and mask (1 = ignore)
//   ch_mode, ch_xfer  2 bits per channel: mode and transfer type
//   rotating_prio     0 fixed priority, 1 rotating priority
//   compressed        1 = skip S3
//   hlda, ready       hold acknowledge, 0 = insert wait state
//   carry_present     upper address reload needed on next cycle of a burst
//   tc, eop_n         per-channel terminal count, external end-of-process
//   hrq, dack, aen    hold request, one-hot acknowledge, address enable
//   adstb, ale, ld_upper_addr  S1 strobes
//   dma_read, dma_write        transfer strobes
//   dec_count, eop_out         S4 count-update and termination pulses
//   active_ch                  channel being serviced
// All outputs are registered and decoded from the state being entered, so
// they line up with the state register (Moore).
// -----------------------------------------------------------------------------
module dma_multichannel_timing_ctrl
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_n,
    input  logic [NUM_CH-1:0]   dreq,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [2*NUM_CH-1:0] ch_mode,
    input  logic [2*NUM_CH-1:0] ch_xfer,
    input  logic                rotating_prio,
    input  logic                compressed,
    input  logic                hlda,
    input  logic                ready,
    input  logic                carry_present,
    input  logic [NUM_CH-1:0]   tc,
    input  logic                eop_n,
    output logic                hrq,
    output logic [NUM_CH-1:0]   dack,
    output logic                aen,
    output logic                adstb,
    output logic                ale,
    output logic                ld_upper_addr,
    output logic                dma_read,
    output logic                dma_write,
    output logic                dec_count,
    output logic                eop_out,
    output logic [CH_W-1:0]     active_ch
);

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    mode_t             mode_reg, mode_next;
    xfer_t             xfer_reg, xfer_next;
    logic [CH_W-1:0]   ptr_reg, ptr_next;
    logic              eop_seen_reg, eop_seen_next;
    logic              term_next;

    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   arb_ptr;
    logic [CH_W-1:0]   grant;
    logic              grant_valid;

    logic              hrq_next, bus_next, s1_next;
    logic              read_next, write_next, dec_next;
    logic [NUM_CH-1:0] dack_next;

    assign pending = dreq & ~ch_mask;
    assign arb_ptr = rotating_prio ? ptr_reg : '0;

    dma_priority_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .pending     (pending),
        .pointer     (arb_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        ch_next       = ch_reg;
        mode_next     = mode_reg;
        xfer_next     = xfer_reg;
        ptr_next      = rotating_prio ? ptr_reg : '0;
        eop_seen_next = eop_seen_reg;

        case (state_reg)
            SI: begin
                if (cs_n && (pending != '0)) begin
                    state_next = S0;
                end
            end
            S0: begin
                if (pending == '0) begin
                    state_next = SI;
                end else if (hlda && grant_valid) begin
                    // Channel, mode and transfer type are frozen for the
                    // whole burst; later reprogramming waits for SI.
                    state_next = S1;
                    ch_next    = grant;
                    mode_next  = decode_mode(ch_mode[{grant, 1'b0} +: 2]);
                    xfer_next  = decode_xfer(ch_xfer[{grant, 1'b0} +: 2]);
                end
            end
            S1: begin
                state_next = hlda ? S2 : SI;
            end
            S2: begin
                if (!hlda) begin
                    state_next = SI;
                end else if (compressed) begin
                    state_next = ready ? S4 : SW;
                end else begin
                    state_next = S3;
                end
            end
            S3: begin
                if (!hlda) begin
                    state_next = SI;
                end else begin
                    state_next = ready ? S4 : SW;
                end
            end
            SW: begin
                if (!hlda) begin
                    state_next = SI;
                end else if (ready) begin
                    state_next = S4;
                end
            end
            S4: begin
                if (rotating_prio) begin
                    ptr_next = (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + 1'b1;
                end
                // eop_out already holds the termination decision for this
                // cycle (taken on entry to S4).
                if (eop_out) begin
                    state_next = SI;
                end else begin
                    case (mode_reg)
                        MODE_BLOCK:  state_next = carry_present ? S1 : S2;
                        MODE_DEMAND: state_next = dreq[ch_reg] ? (carry_present ? S1 : S2) : SI;
                        default:     state_next = SI;
                    endcase
                end
            end
            default: begin
                state_next = SI;
            end
        endcase

        if ((state_reg inside {S1, S2, S3, SW, S4}) && !eop_n) begin
            eop_seen_next = 1'b1;
        end
        if (state_next == SI) begin
            eop_seen_next = 1'b0;
        end
    end

    // Termination is resolved on the edge that enters S4 so eop_out can be a
    // registered pulse aligned with S4. tc and eop_n are therefore sampled on
    // the last cycle before S4; an eop_n low seen during S4 itself is latched
    // and ends the burst at the following S4.
    assign term_next = (state_next == S4) && (tc[ch_reg] || eop_seen_reg || !eop_n);

    // ---------------------------------------------------------------------
    // Output decode from the state being entered
    // ---------------------------------------------------------------------
    assign hrq_next   = (state_next != SI);
    assign bus_next   = (state_next inside {S1, S2, S3, SW, S4});
    assign s1_next    = (state_next == S1);
    assign dec_next   = (state_next == S4);
    assign read_next  = (xfer_next == XFER_READ) && (state_next inside {S2, S3, SW, S4});
    // Compressed timing has no S3, so the write strobe starts in S2.
    assign write_next = (xfer_next == XFER_WRITE) &&
                        ((state_next inside {S3, SW, S4}) || ((state_next == S2) && compressed));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dack
            assign dack_next[gi] = bus_next && (ch_next == CH_W'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SI;
            ch_reg        <= '0;
            mode_reg      <= MODE_SINGLE;
            xfer_reg      <= XFER_VERIFY;
            ptr_reg       <= '0;
            eop_seen_reg  <= 1'b0;
            hrq           <= 1'b0;
            dack          <= '0;
            aen           <= 1'b0;
            adstb         <= 1'b0;
            ale           <= 1'b0;
            ld_upper_addr <= 1'b0;
            dma_read      <= 1'b0;
            dma_write     <= 1'b0;
            dec_count     <= 1'b0;
            eop_out       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ch_reg        <= ch_next;
            mode_reg      <= mode_next;
            xfer_reg      <= xfer_next;
            ptr_reg       <= ptr_next;
            eop_seen_reg  <= eop_seen_next;
            hrq           <= hrq_next;
            dack          <= dack_next;
            aen           <= bus_next;
            adstb         <= s1_next;
            ale           <= s1_next;
            ld_upper_addr <= s1_next;
            dma_read      <= read_next;
            dma_write     <= write_next;
            dec_count     <= dec_next;
            eop_out       <= term_next;
        end
    end

    assign active_ch = ch_reg;

endmodule
